// File: rtl/fbuf_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fbuf_wr_arbiter
//
// Shares the single write port of the downscaled framebuffer BRAM between two
// pixel writers (A and B) and a built-in clear engine that fills the whole
// buffer with one colour.
//
// Ports
//   clk, rst_n          pixel clock, synchronous active-low reset
//   eof                 raster is in vertical blanking (from timing generator)
//   a_valid/a_ready     requester A handshake, a_addr/a_data its payload
//   b_valid/b_ready     requester B handshake, b_addr/b_data its payload
//   clr_start           single-cycle pulse that starts a clear
//   clr_color           fill value, sampled when clr_start is accepted
//   clr_busy            clear in progress (requesters are locked out)
//   clr_done            one-cycle pulse together with the last clear write
//   addr_err            sticky: an out-of-range request was dropped
//   fb_we/fb_addr/fb_wdata  registered BRAM write port
//
// Build option
//   FBUF_ARB_VBLANK_GATE_EN  tearing-free mode: requester grants and clear
//                            writes only happen while eof=1.
// ---------------------------------------------------------------------------
module fbuf_wr_arbiter #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned FB_DEPTH = 32400,
   parameter int unsigned ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              eof,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_data,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_color,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              addr_err,
   output logic              fb_we,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [DATA_W-1:0] fb_wdata
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLR_WAIT,
      CLEAR,
      CLR_END
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_cnt;
   logic [DATA_W-1:0]   clr_color_q;
   logic                last_b;       // last grant went to B -> A has priority
   logic                gate_open;
   logic                clr_accept;
   logic                grant_ok;
   logic                clr_step;
   logic                grant_any;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

`ifdef FBUF_ARB_VBLANK_GATE_EN
   assign gate_open = eof;
`else
   logic unused_eof;
   assign unused_eof = eof;
   assign gate_open  = 1'b1;
`endif

   // Requests are only arbitrated in IDLE; a same-cycle clr_start wins.
   // rst_n gating keeps the handshake quiet while reset is held.
   assign clr_accept = rst_n && (state == IDLE) && clr_start;
   assign grant_ok   = rst_n && (state == IDLE) && !clr_start && gate_open;

   assign a_ready   = grant_ok && a_valid && (!b_valid || last_b);
   assign b_ready   = grant_ok && b_valid && (!a_valid || !last_b);
   assign grant_any = a_ready || b_ready;

   assign sel_addr  = b_ready ? b_addr : a_addr;
   assign sel_data  = b_ready ? b_data : a_data;

   // A clear word is issued in every CLEAR cycle the gate is open; the
   // counter simply holds while the gate is closed.
   assign clr_step  = (state == CLEAR) && gate_open;

   always_comb begin
      state_nxt = state;
      clr_busy  = 1'b0;
      clr_done  = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr_start) state_nxt = CLR_WAIT;
         end
         CLR_WAIT: begin
            clr_busy = 1'b1;
            if (gate_open) state_nxt = CLEAR;
         end
         CLEAR: begin
            clr_busy = 1'b1;
            if (clr_step && (clr_cnt == LAST_ADDR)) state_nxt = CLR_END;
         end
         CLR_END: begin
            clr_busy  = 1'b1;
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         clr_cnt     <= '0;
         clr_color_q <= '0;
         last_b      <= 1'b1;
         addr_err    <= 1'b0;
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         fb_wdata    <= '0;
      end else begin
         state <= state_nxt;
         fb_we <= 1'b0;

         if (clr_accept) begin
            clr_color_q <= clr_color;
            clr_cnt     <= '0;
         end

         if (grant_any) last_b <= b_ready;

         if (clr_step) begin
            clr_cnt  <= clr_cnt + ADDR_W'(1);
            fb_we    <= 1'b1;
            fb_addr  <= clr_cnt;
            fb_wdata <= clr_color_q;
         end else if (grant_any) begin
            // Out-of-range requests are consumed but never reach the BRAM.
            if (sel_addr > LAST_ADDR) begin
               addr_err <= 1'b1;
            end else begin
               fb_we    <= 1'b1;
               fb_addr  <= sel_addr;
               fb_wdata <= sel_data;
            end
         end
      end
   end

endmodule
